// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the FIFO drain path.
//   SKID_DEPTH : number of entries in the skid buffer behind the FIFO read port.
//   ptr_t      : circular-buffer pointer (0..SKID_DEPTH-1).
//   occ_t      : buffer occupancy (0..SKID_DEPTH).
//   ptr_inc    : pointer increment with wrap at SKID_DEPTH.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int unsigned SKID_DEPTH = 3;

    typedef logic [1:0] ptr_t;
    typedef logic [1:0] occ_t;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(SKID_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_skid.sv
// -----------------------------------------------------------------------------
// skid_buf3
//   3-entry circular buffer that catches FIFO read data arriving one cycle
//   after the request, and presents the oldest entry at its head.
//   clk_i   : clock
//   srst_i  : synchronous reset, active-low; empties the buffer and zeroes
//             the storage so the head reads 0 after reset
//   wr_en   : write wr_data at the write pointer
//   wr_data : word to store
//   pop     : discard the head entry (caller guarantees occ != 0)
//   head    : entry at the read pointer
//   occ     : number of valid entries (0..3)
// -----------------------------------------------------------------------------
module skid_buf3
    import fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              pop,
    output logic [DWIDTH-1:0] head,
    output occ_t              occ
);

    logic [DWIDTH-1:0] mem [SKID_DEPTH];
    ptr_t              rd_ptr;
    ptr_t              wr_ptr;
    occ_t              occ_next;

    // Simultaneous write and pop leaves the occupancy unchanged.
    always_comb begin
        occ_next = occ;
        if (wr_en && !pop) begin
            occ_next = occ + occ_t'(1);
        end else if (!wr_en && pop) begin
            occ_next = occ - occ_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            mem    <= '{default: '0};
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            occ <= occ_next;
        end
    end

    assign head = mem[rd_ptr];

    a_no_pop_empty : assert property (@(posedge clk_i) disable iff (!srst_i)
        !(pop && occ == '0));

    a_no_write_full : assert property (@(posedge clk_i) disable iff (!srst_i)
        !(wr_en && !pop && occ == occ_t'(SKID_DEPTH)));

endmodule

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//   Drain stage for a non-showahead FIFO (q valid the cycle after rdreq).
//   Issues FIFO reads, absorbs the read latency in a 3-entry skid buffer and
//   presents the words as a valid/ready stream at up to one word per cycle.
//   clk_i        : clock
//   srst_i       : synchronous reset, active-low
//   fifo_empty_i : FIFO empty flag
//   fifo_q_i     : FIFO read data, valid the cycle after fifo_rdreq_o
//   fifo_rdreq_o : FIFO read request
//   data_o       : stream data (buffer head)
//   valid_o      : data_o holds a word
//   ready_i      : downstream accepts; transfer when valid_o && ready_i
//   xfer_cnt_o   : completed transfers, wraps modulo 2^CWIDTH
// -----------------------------------------------------------------------------
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned CWIDTH = 16
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              fifo_empty_i,
    input  logic [DWIDTH-1:0] fifo_q_i,
    output logic              fifo_rdreq_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CWIDTH-1:0] xfer_cnt_o
);

    logic              inflight;
    occ_t              occ;
    logic              pop;
    logic [2:0]        pending;
    logic [CWIDTH-1:0] xfer_cnt;

    assign valid_o = (occ != '0);
    assign pop     = valid_o && ready_i;

    // Reads are reserved against buffer space including the word already in
    // flight, so the buffer can never overflow. The request depends only on
    // registered state and the FIFO flag; ready_i is deliberately excluded.
    always_comb begin
        pending = {1'b0, occ} + {2'b00, inflight};
    end

    assign fifo_rdreq_o = srst_i && !fifo_empty_i && (pending < 3'(SKID_DEPTH));

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            inflight <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            inflight <= fifo_rdreq_o;
            if (pop) begin
                xfer_cnt <= xfer_cnt + CWIDTH'(1);
            end
        end
    end

    assign xfer_cnt_o = xfer_cnt;

    skid_buf3 #(
        .DWIDTH (DWIDTH)
    ) u_buf (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .wr_en   (inflight),
        .wr_data (fifo_q_i),
        .pop     (pop),
        .head    (data_o),
        .occ     (occ)
    );

    a_no_read_empty : assert property (@(posedge clk_i)
        !(fifo_rdreq_o && fifo_empty_i));

    a_no_overrun : assert property (@(posedge clk_i) disable iff (!srst_i)
        pending <= 3'(SKID_DEPTH));

endmodule
